burst_sched: RTL

BURST_SCHED -- requirements
Module: burst_sched

---
 rtl/burst_sched.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/burst_sched.sv
// burst_sched: burst-mode scheduler for a resonant power stage.
// Splits clk into timing ticks, then drives repeated bursts of gen_en
// from a programmable on-time and period. On-time is capped at MAX_ON
// ticks and off-time is floored at MIN_OFF ticks. An overcurrent fault
// forces a lockout of LOCK_TICKS fault-free ticks.
//
// Ports
//   clk, rst             system clock, synchronous active-high reset
//   cfg_valid            load pulse for cfg_on / cfg_per into pending regs
//   cfg_on, cfg_per      requested on-time and burst period, in ticks
//   arm                  level enable
//   fault                level overcurrent indication
//   gen_en               registered enable to the resonant generator
//   burst_start          one-cycle pulse on the first cycle of each burst
//   state                current state (0 IDLE, 1 ON, 2 OFF, 3 LOCK)
//   fault_cnt            count of lockout entries, saturating at 255
module burst_sched #(
  parameter int unsigned TICK_DIV   = 50,
  parameter int unsigned W          = 16,
  parameter int unsigned MAX_ON     = 200,
  parameter int unsigned MIN_OFF    = 500,
  parameter int unsigned LOCK_TICKS = 10000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_valid,
  input  logic [W-1:0] cfg_on,
  input  logic [W-1:0] cfg_per,
  input  logic         arm,
  input  logic         fault,
  output logic         gen_en,
  output logic         burst_start,
  output logic [1:0]   state,
  output logic [7:0]   fault_cnt
);

  localparam int unsigned   PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [W-1:0]  MAX_ON_W  = W'(MAX_ON);
  localparam logic [W-1:0]  MIN_OFF_W = W'(MIN_OFF);
  localparam logic [W-1:0]  LOCK_LAST = W'(LOCK_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2,
    S_LOCK = 2'd3
  } state_t;

  state_t        cur, nxt;
  logic [PW-1:0] pre;
  logic          tick;
  logic [W-1:0]  cnt, cnt_n;
  logic [W-1:0]  pend_on, pend_per, act_on, act_per;
  logic [W-1:0]  on_eff, off_eff, on_last, off_last;
  logic [W:0]    off_diff;
  logic          pend_ok, load, fault_hit, gen_en_n, burst_start_n;

  assign tick    = (pre == PRE_LAST);
  assign pend_ok = (pend_on != '0) && (pend_per != '0);
  assign state   = cur;

  // Off-time is period minus capped on-time; the extra bit catches a
  // period shorter than the on-time, which falls back to MIN_OFF.
  assign on_eff   = (act_on > MAX_ON_W) ? MAX_ON_W : act_on;
  assign off_diff = {1'b0, act_per} - {1'b0, on_eff};
  assign off_eff  = (off_diff[W] || (off_diff[W-1:0] < MIN_OFF_W)) ? MIN_OFF_W
                                                                   : off_diff[W-1:0];
  assign on_last  = on_eff - W'(1);
  assign off_last = off_eff - W'(1);

  always_comb begin
    nxt       = cur;
    cnt_n     = cnt;
    load      = 1'b0;
    fault_hit = 1'b0;
    if (fault && (cur != S_LOCK)) begin
      nxt       = S_LOCK;
      cnt_n     = '0;
      fault_hit = 1'b1;
    end else begin
      case (cur)
        S_IDLE: begin
          if (tick && arm && pend_ok) begin
            nxt   = S_ON;
            load  = 1'b1;
            cnt_n = '0;
          end
        end
        S_ON: begin
          if (!arm) begin
            nxt   = S_IDLE;
            cnt_n = '0;
          end else if (tick) begin
            if (cnt == on_last) begin
              nxt   = S_OFF;
              cnt_n = '0;
            end else begin
              cnt_n = cnt + W'(1);
            end
          end
        end
        S_OFF: begin
          if (!arm) begin
            nxt   = S_IDLE;
            cnt_n = '0;
          end else if (tick) begin
            if (cnt == off_last) begin
              cnt_n = '0;
              load  = pend_ok;
              nxt   = pend_ok ? S_ON : S_IDLE;
            end else begin
              cnt_n = cnt + W'(1);
            end
          end
        end
        S_LOCK: begin
          // Lockout time only accrues while the fault is clear.
          if (fault) begin
            cnt_n = '0;
          end else if (tick) begin
            if (cnt == LOCK_LAST) begin
              nxt   = S_IDLE;
              cnt_n = '0;
            end else begin
              cnt_n = cnt + W'(1);
            end
          end
        end
        default: ;
      endcase
    end
    // Outputs are registered from the next state so they line up with state.
    gen_en_n      = (nxt == S_ON);
    burst_start_n = (nxt == S_ON) && (cur != S_ON);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur         <= S_IDLE;
      pre         <= '0;
      cnt         <= '0;
      pend_on     <= '0;
      pend_per    <= '0;
      act_on      <= '0;
      act_per     <= '0;
      gen_en      <= 1'b0;
      burst_start <= 1'b0;
      fault_cnt   <= '0;
    end else begin
      cur         <= nxt;
      cnt         <= cnt_n;
      pre         <= tick ? '0 : pre + PW'(1);
      gen_en      <= gen_en_n;
      burst_start <= burst_start_n;
      if (load) begin
        act_on  <= pend_on;
        act_per <= pend_per;
      end
      if (cfg_valid) begin
        pend_on  <= cfg_on;
        pend_per <= cfg_per;
      end
      if (fault_hit && (fault_cnt != 8'hFF)) begin
        fault_cnt <= fault_cnt + 8'd1;
      end
    end
  end

endmodule
